// File: rtl/fir_coeff_pkg.sv
// Shared types for the FIR coefficient loader: default tap width, tap type and
// the loader FSM state encoding.
package fir_coeff_pkg;

  localparam int unsigned DEFAULT_COEFF_BITS = 18;

  typedef logic signed [DEFAULT_COEFF_BITS-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    SWAP,
    FLUSH,
    DONE
  } loader_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register bank: host writes land in shadow,
// a copy strobe moves the whole shadow bank into active in one edge.
module fir_coeff_bank
  import fir_coeff_pkg::*;
#(
  parameter int unsigned NTAPS      = 16,
  parameter int unsigned COEFF_BITS = DEFAULT_COEFF_BITS,
  parameter int unsigned AW         = $clog2(NTAPS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [COEFF_BITS-1:0]         wr_data,
  input  logic                          copy,
  output logic [NTAPS*COEFF_BITS-1:0]   coeff
);

  logic [COEFF_BITS-1:0] shadow [NTAPS];
  logic [COEFF_BITS-1:0] active [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // Copy reads the pre-edge shadow, so a write at the copy edge is not included.
      for (int unsigned i = 0; i < NTAPS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) shadow[i] <= wr_data;
        if (copy) active[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    coeff = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      coeff[i*COEFF_BITS +: COEFF_BITS] = active[i];
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for a bank of 4-tap systolic FIR stages: shadow writes,
// atomic shadow->active swap, then DSP reset held while the pipeline flushes.
module fir_coeff_loader
  import fir_coeff_pkg::*;
#(
  parameter int unsigned NTAPS        = 16,
  parameter int unsigned COEFF_BITS   = DEFAULT_COEFF_BITS,
  parameter int unsigned FLUSH_CYCLES = 12,
  // One spare address bit so out-of-range indices (>= NTAPS) are expressible.
  localparam int unsigned AW          = $clog2(NTAPS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [AW-1:0]                 wr_addr_i,
  input  logic [COEFF_BITS-1:0]         wr_data_i,
  input  logic                          commit_i,
  output logic                          busy_o,
  output logic                          addr_err_o,
  output logic                          dsp_rst_o,
  output logic                          update_o,
  output logic [NTAPS*COEFF_BITS-1:0]   coeff_o
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

  loader_state_e state_q, state_d;
  logic [CW-1:0] flush_cnt;
  logic          ready_d, busy_d, dsp_rst_d, update_d;
  logic          wr_fire, in_range;

  assign wr_fire  = wr_valid_i && wr_ready_o;
  assign in_range = (wr_addr_i < AW'(NTAPS));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_i) state_d = SWAP;
      SWAP:    state_d = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
      FLUSH:   if (flush_cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they can be registered.
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    dsp_rst_d = (state_d == SWAP) || (state_d == FLUSH);
    update_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      wr_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      dsp_rst_o  <= 1'b1;
      update_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ready_o <= ready_d;
      busy_o     <= busy_d;
      dsp_rst_o  <= dsp_rst_d;
      update_o   <= update_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flush_cnt <= '0;
    end else if (state_q == SWAP) begin
      flush_cnt <= FLUSH_LOAD;
    end else if ((state_q == FLUSH) && (flush_cnt != '0)) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_err_o <= 1'b0;
    end else if (state_q == DONE) begin
      addr_err_o <= 1'b0;
    end else if (wr_fire && !in_range) begin
      addr_err_o <= 1'b1;
    end
  end

  fir_coeff_bank #(
    .NTAPS      (NTAPS),
    .COEFF_BITS (COEFF_BITS),
    .AW         (AW)
  ) u_bank (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .wr_en   (wr_fire && in_range),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .copy    (state_q == SWAP),
    .coeff   (coeff_o)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: a tap-array model of the shadow and
// active banks plus latency expectations derived from the flush length.
module tb_fir_coeff_loader;

  localparam int unsigned NTAPS = 16;
  localparam int unsigned CB    = 18;
  localparam int unsigned FC    = 12;
  localparam int unsigned AW    = 5;
  localparam int unsigned W     = NTAPS * CB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CB-1:0] wr_data = '0;
  logic          commit = 1'b0;
  logic          wr_ready, busy, addr_err, dsp_rst, update;
  logic [W-1:0]  coeff;

  logic          z_wr_valid = 1'b0;
  logic [AW-1:0] z_wr_addr = '0;
  logic [CB-1:0] z_wr_data = '0;
  logic          z_commit = 1'b0;
  logic          z_wr_ready, z_busy, z_addr_err, z_dsp_rst, z_update;
  logic [W-1:0]  z_coeff;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CB-1:0] model_shadow [NTAPS];
  logic [CB-1:0] model_active [NTAPS];
  bit            model_err;

  always #5 clk = ~clk;

  fir_coeff_loader #(.NTAPS(NTAPS), .COEFF_BITS(CB), .FLUSH_CYCLES(FC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .commit_i(commit), .busy_o(busy),
    .addr_err_o(addr_err), .dsp_rst_o(dsp_rst), .update_o(update), .coeff_o(coeff)
  );

  fir_coeff_loader #(.NTAPS(NTAPS), .COEFF_BITS(CB), .FLUSH_CYCLES(0)) dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .wr_valid_i(z_wr_valid), .wr_ready_o(z_wr_ready),
    .wr_addr_i(z_wr_addr), .wr_data_i(z_wr_data), .commit_i(z_commit), .busy_o(z_busy),
    .addr_err_o(z_addr_err), .dsp_rst_o(z_dsp_rst), .update_o(z_update), .coeff_o(z_coeff)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      model_shadow[i] = '0;
      model_active[i] = '0;
    end
    model_err = 1'b0;
  endfunction

  function automatic void model_write(input int unsigned addr, input logic [CB-1:0] data);
    if (addr < NTAPS) model_shadow[addr] = data;
    else model_err = 1'b1;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < NTAPS; i++) model_active[i] = model_shadow[i];
    model_err = 1'b0;
  endfunction

  function automatic logic [W-1:0] active_vec();
    logic [W-1:0] v;
    for (int i = 0; i < NTAPS; i++) v[i*CB +: CB] = model_active[i];
    return v;
  endfunction

  task automatic write_tap(input int unsigned addr, input logic [CB-1:0] data);
    bit done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_data  = data;
    for (int i = 0; i < 50 && !done; i++) begin
      done = wr_ready;
      step();
    end
    wr_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL write_accept addr=%0d: got no accept, expected accept within 50 cycles", addr);
    end else begin
      model_write(addr, data);
    end
  endtask

  // Commit for one cycle, then observe after edge j (j=0 is the commit edge).
  // Observation j lies in cycle k+j+1 when the commit cycle ends at edge k.
  task automatic run_commit(input int pulse_at, input bit late_write,
                            output int upd_first, output int upd_count, output int rst_cnt,
                            output int coeff_first, output int coeff_changes,
                            output int overlap, output int write_j, output int err_low_first);
    logic [W-1:0] prev;
    upd_first = -1; upd_count = 0; rst_cnt = 0; coeff_first = -1; coeff_changes = 0;
    overlap = 0; write_j = -1; err_low_first = -1;
    prev = coeff;
    commit = 1'b1;
    step();
    commit = 1'b0;
    wr_valid = 1'b0;
    for (int j = 0; j <= int'(FC) + 6; j++) begin
      if (update) begin
        upd_count++;
        if (upd_first < 0) upd_first = j;
      end
      if (dsp_rst) rst_cnt++;
      if (coeff !== prev) begin
        coeff_changes++;
        if (coeff_first < 0) coeff_first = j;
        prev = coeff;
      end
      if (busy && wr_ready) overlap++;
      if (!addr_err && err_low_first < 0) err_low_first = j;
      commit = (j == pulse_at);
      if (late_write && j == 2) wr_valid = 1'b1;
      if (wr_valid && wr_ready && write_j < 0) write_j = j;
      step();
      if (write_j == j) wr_valid = 1'b0;
    end
    commit = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    n_checks++; if (dsp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_dsp_rst got=%b exp=1", dsp_rst); end
    n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update got=%b exp=0", update); end
    n_checks++; if (coeff !== '0) begin n_fail++; $display("FAIL reset_coeff got=%h exp=0", coeff); end
    rst_n = 1'b1;
    #2;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL release_pre_edge_ready got=%b exp=0", wr_ready); end
    step();
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_wr_ready got=%b exp=1", wr_ready); end
    n_checks++; if (dsp_rst !== 1'b0) begin n_fail++; $display("FAIL release_dsp_rst got=%b exp=0", dsp_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy got=%b exp=0", busy); end
    n_checks++; if (z_wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_z_wr_ready got=%b exp=1", z_wr_ready); end
  endtask

  task automatic test_load_commit();
    int uf, uc, rc, cf, cc, ov, wj, el;
    for (int n = 0; n < NTAPS; n++) write_tap(n, CB'(n * 'h101));
    n_checks++; if (coeff !== '0) begin n_fail++; $display("FAIL shadow_only got=%h exp=0", coeff); end
    run_commit(-1, 1'b0, uf, uc, rc, cf, cc, ov, wj, el);
    model_commit();
    n_checks++; if (uf != int'(FC) + 1) begin n_fail++; $display("FAIL update_latency got=%0d exp=%0d", uf, FC + 1); end
    n_checks++; if (uc != 1) begin n_fail++; $display("FAIL update_count got=%0d exp=1", uc); end
    n_checks++; if (rc != int'(FC) + 1) begin n_fail++; $display("FAIL dsp_rst_cycles got=%0d exp=%0d", rc, FC + 1); end
    n_checks++; if (cf != 1) begin n_fail++; $display("FAIL coeff_swap_edge got=%0d exp=1", cf); end
    n_checks++; if (cc != 1) begin n_fail++; $display("FAIL coeff_change_count got=%0d exp=1", cc); end
    n_checks++; if (ov != 0) begin n_fail++; $display("FAIL ready_while_busy got=%0d exp=0", ov); end
    n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL load_coeff got=%h exp=%h", coeff, active_vec()); end
    n_checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL back_to_idle busy=%b ready=%b exp busy=0 ready=1", busy, wr_ready); end
  endtask

  task automatic test_commit_write_same_edge();
    int uf, uc, rc, cf, cc, ov, wj, el;
    wr_valid = 1'b1;
    wr_addr  = AW'(3);
    wr_data  = 18'h3FFFF;
    model_write(3, 18'h3FFFF);
    run_commit(-1, 1'b0, uf, uc, rc, cf, cc, ov, wj, el);
    model_commit();
    n_checks++; if (coeff[3*CB +: CB] !== 18'h3FFFF) begin n_fail++; $display("FAIL same_edge_tap3 got=%h exp=3ffff", coeff[3*CB +: CB]); end
    n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL same_edge_bank got=%h exp=%h", coeff, active_vec()); end
  endtask

  task automatic test_addr_error();
    int uf, uc, rc, cf, cc, ov, wj, el;
    write_tap(16, CB'($urandom));
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_set got=%b exp=1", addr_err); end
    run_commit(-1, 1'b0, uf, uc, rc, cf, cc, ov, wj, el);
    model_commit();
    n_checks++; if (el != int'(FC) + 2) begin n_fail++; $display("FAIL addr_err_clear_time got=%0d exp=%0d", el, FC + 2); end
    n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL addr_err_bank got=%h exp=%h", coeff, active_vec()); end
  endtask

  task automatic test_busy_ignore();
    int uf, uc, rc, cf, cc, ov, wj, el;
    int unsigned a;
    logic [CB-1:0] d;
    write_tap($urandom_range(0, NTAPS - 1), CB'($urandom));
    a = $urandom_range(0, NTAPS - 1);
    d = CB'($urandom);
    wr_addr = AW'(a);
    wr_data = d;
    run_commit(5, 1'b1, uf, uc, rc, cf, cc, ov, wj, el);
    model_commit();
    n_checks++; if (uc != 1) begin n_fail++; $display("FAIL flush_commit_ignored updates=%0d exp=1", uc); end
    n_checks++; if (uf != int'(FC) + 1) begin n_fail++; $display("FAIL flush_commit_latency got=%0d exp=%0d", uf, FC + 1); end
    n_checks++; if (ov != 0) begin n_fail++; $display("FAIL stall_ready got=%0d exp=0", ov); end
    n_checks++; if (wj != int'(FC) + 2) begin n_fail++; $display("FAIL stalled_write_accept got=%0d exp=%0d", wj, FC + 2); end
    if (wj >= 0) model_write(a, d);
    n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL stall_active got=%h exp=%h", coeff, active_vec()); end
    run_commit(-1, 1'b0, uf, uc, rc, cf, cc, ov, wj, el);
    model_commit();
    n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL stalled_write_landed got=%h exp=%h", coeff, active_vec()); end
  endtask

  task automatic test_random();
    int uf, uc, rc, cf, cc, ov, wj, el;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 6; w++) write_tap($urandom_range(0, 20), CB'($urandom));
      n_checks++; if (addr_err !== model_err) begin n_fail++; $display("FAIL rand_addr_err round=%0d got=%b exp=%b", r, addr_err, model_err); end
      run_commit(-1, 1'b0, uf, uc, rc, cf, cc, ov, wj, el);
      model_commit();
      n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL rand_bank round=%0d got=%h exp=%h", r, coeff, active_vec()); end
      n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL rand_err_cleared round=%0d got=%b exp=0", r, addr_err); end
    end
  endtask

  task automatic test_reset_mid_flush();
    int uf, uc, rc, cf, cc, ov, wj, el;
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (5) step();
    n_checks++; if (busy !== 1'b1 || dsp_rst !== 1'b1) begin n_fail++; $display("FAIL in_flush busy=%b dsp_rst=%b exp 1 1", busy, dsp_rst); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (coeff !== '0) begin n_fail++; $display("FAIL async_coeff_clear got=%h exp=0", coeff); end
    n_checks++; if (busy !== 1'b0 || dsp_rst !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL async_ctrl busy=%b dsp_rst=%b ready=%b exp 0 1 0", busy, dsp_rst, wr_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_checks++; if (wr_ready !== 1'b1 || busy !== 1'b0 || dsp_rst !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle ready=%b busy=%b dsp_rst=%b exp 1 0 0", wr_ready, busy, dsp_rst); end
    write_tap($urandom_range(0, NTAPS - 1), CB'($urandom) | 18'h1);
    run_commit(-1, 1'b0, uf, uc, rc, cf, cc, ov, wj, el);
    model_commit();
    n_checks++; if (coeff !== active_vec()) begin n_fail++; $display("FAIL no_partial_bank got=%h exp=%h", coeff, active_vec()); end
  endtask

  task automatic test_zero_flush();
    int unsigned a;
    logic [CB-1:0] d;
    logic [W-1:0] exp_vec;
    int uf, rc, cf;
    bit ok;
    a = $urandom_range(0, NTAPS - 1);
    d = CB'($urandom) | 18'h1;
    exp_vec = '0;
    exp_vec[a*CB +: CB] = d;
    uf = -1; rc = 0; cf = -1; ok = 1'b0;
    z_wr_valid = 1'b1;
    z_wr_addr  = AW'(a);
    z_wr_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = z_wr_ready;
      step();
    end
    z_wr_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL z_write_accept got=0 exp=1"); end
    z_commit = 1'b1;
    step();
    z_commit = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (z_update && uf < 0) uf = j;
      if (z_dsp_rst) rc++;
      if (z_coeff !== '0 && cf < 0) cf = j;
      step();
    end
    n_checks++; if (uf != 1) begin n_fail++; $display("FAIL z_update_latency got=%0d exp=1", uf); end
    n_checks++; if (rc != 1) begin n_fail++; $display("FAIL z_dsp_rst_cycles got=%0d exp=1", rc); end
    n_checks++; if (cf != 1) begin n_fail++; $display("FAIL z_coeff_swap_edge got=%0d exp=1", cf); end
    n_checks++; if (z_coeff !== exp_vec) begin n_fail++; $display("FAIL z_bank got=%h exp=%h", z_coeff, exp_vec); end
    n_checks++; if (z_busy !== 1'b0) begin n_fail++; $display("FAIL z_idle busy=%b exp=0", z_busy); end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_commit_write_same_edge();
    test_addr_error();
    test_busy_ignore();
    test_random();
    test_reset_mid_flush();
    test_zero_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
